// File: rtl/clock_pkg.sv
// clock_pkg: field encodings, BCD limits, FSM states and the BCD step helper
// shared by the time-set front panel.
package clock_pkg;
   localparam logic [1:0] TYPE_NONE = 2'd0;
   localparam logic [1:0] TYPE_SEC  = 2'd1;
   localparam logic [1:0] TYPE_MIN  = 2'd2;
   localparam logic [1:0] TYPE_HR   = 2'd3;
   localparam logic [7:0] SEC_MAX   = 8'h59;
   localparam logic [7:0] MIN_MAX   = 8'h59;
   localparam logic [7:0] HR_MAX    = 8'h23;
   typedef enum logic [2:0] {IDLE, EDIT_SEC, EDIT_MIN, EDIT_HR, LOAD} state_e;
   // Wraps between 00 and lim in both directions; tens/units stay valid BCD.
   function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] lim, input logic up);
      if (up) begin
         if (v == lim) return 8'h00;
         if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
         return {v[7:4], v[3:0] + 4'd1};
      end
      if (v == 8'h00) return lim;
      if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
      return {v[7:4], v[3:0] - 4'd1};
   endfunction
endpackage

// File: rtl/btn_edge.sv
// btn_edge: synchronizes a raw button and emits one pulse per rising edge.
module btn_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic pulse_o
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   assign pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= (sync_q << 1) | SYNC_STAGES'(btn_i);
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven field select and BCD entry for the 24h clock,
// presenting set/type and holding confirm low long enough for a slow-tick sample.
module time_set_ctrl
   import clock_pkg::*;
#(
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode_i,
   input  logic       btn_inc_i,
   input  logic       btn_dec_i,
   input  logic       btn_enter_i,
   output logic [7:0] set_o,
   output logic [1:0] type_o,
   output logic       confirm_o,
   output logic       busy_o
);
   localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
   logic          mode_p, inc_p, dec_p, enter_p;
   state_e        state_q, state_d, ret_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    sec_q, min_q, hr_q, sec_d, min_d, hr_d, cur, step, set_d;
   logic [1:0]    type_d;
   logic          done, modify;
   btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mode  (.clk(clk), .reset(reset), .btn_i(btn_mode_i),  .pulse_o(mode_p));
   btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_inc   (.clk(clk), .reset(reset), .btn_i(btn_inc_i),   .pulse_o(inc_p));
   btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dec   (.clk(clk), .reset(reset), .btn_i(btn_dec_i),   .pulse_o(dec_p));
   btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_enter (.clk(clk), .reset(reset), .btn_i(btn_enter_i), .pulse_o(enter_p));
   // Outputs are derived from next-state values so set/type/confirm change together.
   always_comb begin
      done    = cnt_q == CW'(HOLD_CYCLES - 1);
      cur     = state_q == EDIT_MIN ? min_q : state_q == EDIT_HR ? hr_q : sec_q;
      step    = bcd_step(cur, state_q == EDIT_HR ? HR_MAX : state_q == EDIT_MIN ? MIN_MAX : SEC_MAX, inc_p);
      modify  = !enter_p && !mode_p && (inc_p ^ dec_p);
      sec_d   = modify && state_q == EDIT_SEC ? step : sec_q;
      min_d   = modify && state_q == EDIT_MIN ? step : min_q;
      hr_d    = modify && state_q == EDIT_HR  ? step : hr_q;
      state_d = state_q == LOAD ? (done ? ret_q : LOAD) :
                state_q == IDLE ? (mode_p ? EDIT_SEC : IDLE) :
                enter_p ? LOAD :
                mode_p ? (state_q == EDIT_SEC ? EDIT_MIN : state_q == EDIT_MIN ? EDIT_HR : IDLE) :
                state_q;
      cnt_d   = state_q == LOAD && !done ? cnt_q + 1'b1 : '0;
      set_d   = state_d == EDIT_SEC ? sec_d : state_d == EDIT_MIN ? min_d :
                state_d == EDIT_HR ? hr_d : state_d == LOAD ? set_o : 8'h00;
      type_d  = state_d == EDIT_SEC ? TYPE_SEC : state_d == EDIT_MIN ? TYPE_MIN :
                state_d == EDIT_HR ? TYPE_HR : state_d == LOAD ? type_o : TYPE_NONE;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         ret_q     <= EDIT_SEC;
         cnt_q     <= '0;
         sec_q     <= 8'h00;
         min_q     <= 8'h00;
         hr_q      <= 8'h00;
         set_o     <= 8'h00;
         type_o    <= TYPE_NONE;
         confirm_o <= 1'b1;
         busy_o    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ret_q     <= state_d == LOAD && state_q != LOAD ? state_q : ret_q;
         cnt_q     <= cnt_d;
         sec_q     <= sec_d;
         min_q     <= min_d;
         hr_q      <= hr_d;
         set_o     <= set_d;
         type_o    <= type_d;
         confirm_o <= state_d != LOAD;
         busy_o    <= state_d == LOAD;
      end
   end
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: table-driven button sequences with a scoreboard of expected
// panel outputs, plus hand-written load, coincidence and mid-load reset cases.
module tb_time_set_ctrl;
   localparam logic [3:0] B_MODE = 4'b0001, B_INC = 4'b0010, B_DEC = 4'b0100, B_ENTER = 4'b1000;
   logic       clk = 1'b0, reset = 1'b1;
   logic [3:0] btns = 4'b0;
   logic [7:0] set_o;
   logic [1:0] type_o;
   logic       confirm_o, busy_o;
   int         checks = 0, errors = 0;
   typedef struct {
      logic [3:0] btn;
      int         n;
      logic [7:0] set;
      logic [1:0] typ;
   } vec_t;
   typedef struct packed {
      logic [7:0] set;
      logic [1:0] typ;
      logic       confirm;
      logic       busy;
   } exp_t;
   vec_t tv[18];
   exp_t exp_q[$];
   time_set_ctrl #(.HOLD_CYCLES(4), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset),
      .btn_mode_i(btns[0]), .btn_inc_i(btns[1]), .btn_dec_i(btns[2]), .btn_enter_i(btns[3]),
      .set_o(set_o), .type_o(type_o), .confirm_o(confirm_o), .busy_o(busy_o)
   );
   always #5 clk = ~clk;
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask
   task automatic push(input logic [7:0] s, input logic [1:0] t);
      exp_q.push_back('{set: s, typ: t, confirm: 1'b1, busy: 1'b0});
   endtask
   task automatic pop_check(input string name);
      exp_t e;
      e = exp_q.pop_front();
      chk(name, {20'd0, set_o, type_o, confirm_o, busy_o}, {20'd0, e});
   endtask
   task automatic press(input logic [3:0] m, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); btns = m;
         @(negedge clk); btns = 4'b0;
         repeat (5) @(negedge clk);
      end
   endtask
   task automatic watch_load(input string name, input logic [7:0] s, input logic [1:0] t);
      int low = 0, frozen_bad = 0, busy_bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!confirm_o) begin
            low++;
            if (set_o != s || type_o != t) frozen_bad++;
         end
         if (busy_o == confirm_o) busy_bad++;
      end
      chk({name, " hold length"}, low, 4);
      chk({name, " frozen set/type"}, frozen_bad, 0);
      chk({name, " busy vs confirm"}, busy_bad, 0);
   endtask
   initial begin
      int bad = 0, waited = 0;
      tv[0]  = '{B_MODE, 1, 8'h00, 2'd1};
      tv[1]  = '{B_INC, 10, 8'h10, 2'd1};
      tv[2]  = '{B_DEC, 11, 8'h59, 2'd1};
      tv[3]  = '{B_MODE, 1, 8'h00, 2'd2};
      tv[4]  = '{B_MODE, 1, 8'h00, 2'd3};
      tv[5]  = '{B_DEC, 1, 8'h23, 2'd3};
      tv[6]  = '{B_INC, 1, 8'h00, 2'd3};
      tv[7]  = '{B_INC, 20, 8'h20, 2'd3};
      tv[8]  = '{B_INC | B_DEC, 1, 8'h20, 2'd3};
      tv[9]  = '{B_MODE, 1, 8'h00, 2'd0};
      tv[10] = '{B_INC, 1, 8'h00, 2'd0};
      tv[11] = '{B_ENTER, 1, 8'h00, 2'd0};
      tv[12] = '{B_MODE, 2, 8'h00, 2'd2};
      tv[13] = '{B_DEC, 18, 8'h42, 2'd2};
      tv[14] = '{B_MODE | B_INC, 1, 8'h20, 2'd3};
      tv[15] = '{B_MODE, 1, 8'h00, 2'd0};
      tv[16] = '{B_MODE, 1, 8'h59, 2'd1};
      tv[17] = '{B_MODE, 1, 8'h42, 2'd2};
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (set_o !== 8'h00 || type_o !== 2'd0 || confirm_o !== 1'b1 || busy_o !== 1'b0) bad++;
      end
      chk("idle after reset (cycles off)", bad, 0);
      for (int i = 0; i < 18; i++) begin
         push(tv[i].set, tv[i].typ);
         press(tv[i].btn, tv[i].n);
         pop_check($sformatf("vector %0d", i));
      end
      @(negedge clk); btns = B_ENTER;
      @(negedge clk); btns = B_INC | B_MODE;
      @(negedge clk); btns = 4'b0;
      watch_load("load min", 8'h42, 2'd2);
      push(8'h42, 2'd2);
      pop_check("after load");
      push(8'h43, 2'd2);
      press(B_INC, 1);
      pop_check("back in edit min inc");
      push(8'h42, 2'd2);
      press(B_DEC, 1);
      pop_check("back in edit min dec");
      @(negedge clk); btns = B_ENTER | B_INC;
      @(negedge clk); btns = 4'b0;
      watch_load("enter+inc", 8'h42, 2'd2);
      push(8'h42, 2'd2);
      pop_check("enter beats inc");
      @(negedge clk); btns = B_ENTER;
      @(negedge clk); btns = 4'b0;
      while (confirm_o && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      chk("load started before reset", confirm_o, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("async confirm on reset", confirm_o, 1'b1);
      chk("busy on reset", busy_o, 1'b0);
      chk("type on reset", type_o, 2'd0);
      chk("set on reset", set_o, 8'h00);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      push(8'h00, 2'd1);
      press(B_MODE, 1);
      pop_check("sec cleared");
      push(8'h00, 2'd2);
      press(B_MODE, 1);
      pop_check("min cleared");
      push(8'h00, 2'd3);
      press(B_MODE, 1);
      pop_check("hr cleared");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
